// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard over the shared open-drain
// ps2_clk/ps2_dat lines. Each line is driven through an active-high pull-low
// enable; the pad releases the line to its pull-up when the enable is 0.
// busy tells the receive path to ignore the lines while a transfer runs.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_strobe,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    // The inhibit phase ends when the counter shows INHIBIT_CYCLES-1.
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    // error is registered in the same edge that moves the counter onto
    // TIMEOUT_CYCLES-1, so the pulse lands TIMEOUT_CYCLES cycles after the
    // cycle holding the fall_det that last cleared the counter.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 2);

    logic             clk_s1, clk_s2;
    logic             dat_s1, dat_s2;
    logic [3:0]       flt_cnt;
    logic             fall_det;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [9:0]       shreg, shreg_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic             clk_oe_nxt, dat_oe_nxt;
    logic             busy_nxt, done_nxt, error_nxt;
    logic             timed_out;

    // Two-stage synchronizers for both pins; idle lines read as 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Falling-edge qualifier: the device clock must stay low 15 cycles
    // before one fall_det pulse is produced, so short glitches are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt  <= 4'h0;
            fall_det <= 1'b0;
        end else begin
            if (clk_s2) begin
                flt_cnt <= 4'h0;
            end else if (flt_cnt != 4'hF) begin
                flt_cnt <= flt_cnt + 4'd1;
            end
            fall_det <= !clk_s2 && (flt_cnt == 4'hE);
        end
    end

    // State, counters, shift register and all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bit_cnt    <= 4'd0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            ps2_clk_oe <= clk_oe_nxt;
            ps2_dat_oe <= dat_oe_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

    // Next-state logic; a timeout overrides whatever the state decided.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        clk_oe_nxt  = ps2_clk_oe;
        dat_oe_nxt  = ps2_dat_oe;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        timed_out   = ((state == SEND) || (state == ACK) || (state == WAIT_IDLE))
                      && (cnt == TO_LAST);

        case (state)
            IDLE: begin
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b0;
                busy_nxt   = 1'b0;
                if (wr_strobe && !done && !error) begin
                    shreg_nxt = {1'b1, ~^wr_data, wr_data};
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                clk_oe_nxt = 1'b1;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == INH_LAST) begin
                    dat_oe_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = RELEASE;
                end
            end
            RELEASE: begin
                clk_oe_nxt  = 1'b0;
                bit_cnt_nxt = 4'd0;
                cnt_nxt     = '0;
                state_nxt   = SEND;
            end
            SEND: begin
                cnt_nxt = cnt + 1'b1;
                if (fall_det) begin
                    dat_oe_nxt  = ~shreg[0];
                    shreg_nxt   = {1'b0, shreg[9:1]};
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    cnt_nxt     = '0;
                    if (bit_cnt == 4'd9) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                cnt_nxt = cnt + 1'b1;
                if (fall_det) begin
                    cnt_nxt = '0;
                    if (!dat_s2) begin
                        state_nxt = WAIT_IDLE;
                    end else begin
                        error_nxt  = 1'b1;
                        busy_nxt   = 1'b0;
                        clk_oe_nxt = 1'b0;
                        dat_oe_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_nxt = cnt + 1'b1;
                if (clk_s2 && dat_s2) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (timed_out) begin
            done_nxt   = 1'b0;
            error_nxt  = 1'b1;
            busy_nxt   = 1'b0;
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            state_nxt  = IDLE;
        end
    end

endmodule
